// File: rtl/demux_fill_ctrl.sv
// demux_fill_ctrl: round-robin sequencer for a 1-to-4 word demultiplexer.
// Serial words are captured into four lane registers. The completed vector
// is then offered downstream through a valid/ready handshake, and the
// number of delivered vectors is counted.
module demux_fill_ctrl #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [1:0]        sel,
  output logic [3:0]        lane_we,
  output logic [DATA_W-1:0] lane_0,
  output logic [DATA_W-1:0] lane_1,
  output logic [DATA_W-1:0] lane_2,
  output logic [DATA_W-1:0] lane_3,
  output logic              vec_valid,
  input  logic              vec_ready,
  output logic [CNT_W-1:0]  vec_cnt
);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state_q;
  logic [1:0]        sel_q;
  logic [3:0]        lane_we_q;
  logic [DATA_W-1:0] lane0_q;
  logic [DATA_W-1:0] lane1_q;
  logic [DATA_W-1:0] lane2_q;
  logic [DATA_W-1:0] lane3_q;
  logic [CNT_W-1:0]  cnt_q;

  logic in_ready_s;
  logic accept_s;
  logic take_s;

  // Handshake decode: in_ready depends only on state, flush and vec_ready.
  // A held vector frees its slot only when it is taken, so the word for
  // lane 0 can be accepted in that same cycle.
  always_comb begin
    in_ready_s = 1'b0;
    if (flush) begin
      in_ready_s = 1'b0;
    end else if (state_q == FILL) begin
      in_ready_s = 1'b1;
    end else begin
      in_ready_s = vec_ready;
    end
    accept_s = in_valid & in_ready_s;
    take_s   = (state_q == FULL) & vec_ready;
  end

  // Fill/hold state machine with lane capture, write strobes and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      sel_q     <= 2'd0;
      lane_we_q <= 4'b0000;
      lane0_q   <= '0;
      lane1_q   <= '0;
      lane2_q   <= '0;
      lane3_q   <= '0;
      cnt_q     <= '0;
    end else if (flush) begin
      state_q   <= FILL;
      sel_q     <= 2'd0;
      lane_we_q <= 4'b0000;
      lane0_q   <= '0;
      lane1_q   <= '0;
      lane2_q   <= '0;
      lane3_q   <= '0;
    end else begin
      case (state_q)
        FILL: begin
          lane_we_q <= 4'b0000;
          if (accept_s) begin
            case (sel_q)
              2'd0:    lane0_q <= in_data;
              2'd1:    lane1_q <= in_data;
              2'd2:    lane2_q <= in_data;
              2'd3:    lane3_q <= in_data;
              default: lane0_q <= lane0_q;
            endcase
            lane_we_q <= 4'b0001 << sel_q;
            if (sel_q == 2'd3) begin
              sel_q   <= 2'd0;
              state_q <= FULL;
            end else begin
              sel_q <= sel_q + 2'd1;
            end
          end
        end
        FULL: begin
          lane_we_q <= 4'b0000;
          if (take_s) begin
            cnt_q   <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            state_q <= FILL;
            if (accept_s) begin
              lane0_q   <= in_data;
              lane_we_q <= 4'b0001;
              sel_q     <= 2'd1;
            end
          end
        end
        default: begin
          state_q   <= FILL;
          sel_q     <= 2'd0;
          lane_we_q <= 4'b0000;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign sel       = sel_q;
  assign lane_we   = lane_we_q;
  assign lane_0    = lane0_q;
  assign lane_1    = lane1_q;
  assign lane_2    = lane2_q;
  assign lane_3    = lane3_q;
  assign vec_valid = (state_q == FULL);
  assign vec_cnt   = cnt_q;

endmodule

// File: tb/tb_demux_fill_ctrl.sv
// Directed, table-driven bench for demux_fill_ctrl. A second instance with a
// 2-bit counter shares all inputs to observe counter wrap-around.
module tb_demux_fill_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  sel;
  logic [3:0]  lane_we;
  logic [15:0] lane_0, lane_1, lane_2, lane_3;
  logic        vec_valid;
  logic        vec_ready;
  logic [7:0]  vec_cnt;

  logic        in_ready2;
  logic [1:0]  sel2;
  logic [3:0]  lane_we2;
  logic [15:0] l2_0, l2_1, l2_2, l2_3;
  logic        vec_valid2;
  logic [1:0]  vec_cnt2;

  int checks = 0;
  int failures = 0;
  logic ir_pre;

  always #5 clk = ~clk;

  demux_fill_ctrl #(.DATA_W(16), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .sel(sel), .lane_we(lane_we),
    .lane_0(lane_0), .lane_1(lane_1), .lane_2(lane_2), .lane_3(lane_3),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_cnt(vec_cnt)
  );

  demux_fill_ctrl #(.DATA_W(16), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready2), .sel(sel2), .lane_we(lane_we2),
    .lane_0(l2_0), .lane_1(l2_1), .lane_2(l2_2), .lane_3(l2_3),
    .vec_valid(vec_valid2), .vec_ready(vec_ready), .vec_cnt(vec_cnt2)
  );

  typedef struct packed {
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        f;
    logic        ir;
    logic [1:0]  sel;
    logic [3:0]  we;
    logic        vv;
    logic [7:0]  cnt;
    logic [15:0] l0;
    logic [15:0] l1;
    logic [15:0] l2;
    logic [15:0] l3;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(input logic v, input logic [15:0] d, input logic r,
                              input logic f, input logic ir, input logic [1:0] s,
                              input logic [3:0] we, input logic vv, input logic [7:0] cnt,
                              input logic [15:0] l0, input logic [15:0] l1,
                              input logic [15:0] l2, input logic [15:0] l3);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.f = f; t.ir = ir; t.sel = s; t.we = we;
    t.vv = vv; t.cnt = cnt; t.l0 = l0; t.l1 = l1; t.l2 = l2; t.l3 = l3;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle: inputs set after an edge, in_ready sampled before the
  // next edge, outputs left to be checked 1 time unit after that edge.
  task automatic step(input logic v, input logic [15:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    vec_ready = r;
    flush     = f;
    #3;
    ir_pre = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [1:0] s, input logic [3:0] we,
                         input logic vv, input logic [7:0] cnt,
                         input logic [15:0] l0, input logic [15:0] l1,
                         input logic [15:0] l2, input logic [15:0] l3);
    chk({tag, ".sel"}, {30'd0, sel}, {30'd0, s});
    chk({tag, ".lane_we"}, {28'd0, lane_we}, {28'd0, we});
    chk({tag, ".vec_valid"}, {31'd0, vec_valid}, {31'd0, vv});
    chk({tag, ".vec_cnt"}, {24'd0, vec_cnt}, {24'd0, cnt});
    chk({tag, ".vec_cnt2"}, {30'd0, vec_cnt2}, {30'd0, cnt[1:0]});
    chk({tag, ".lane_0"}, {16'd0, lane_0}, {16'd0, l0});
    chk({tag, ".lane_1"}, {16'd0, lane_1}, {16'd0, l1});
    chk({tag, ".lane_2"}, {16'd0, lane_2}, {16'd0, l2});
    chk({tag, ".lane_3"}, {16'd0, lane_3}, {16'd0, l3});
  endtask

  initial begin
    // Stream 11..44, hold with vec_ready low, take+accept, refill,
    // take without accept, partial load + flush, fresh vector, flush vs take.
    tbl[0]  = mk(1'b1, 16'h0011, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0001, 1'b0, 8'd0, 16'h0011, 16'h0000, 16'h0000, 16'h0000);
    tbl[1]  = mk(1'b1, 16'h0022, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 1'b0, 8'd0, 16'h0011, 16'h0022, 16'h0000, 16'h0000);
    tbl[2]  = mk(1'b1, 16'h0033, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0100, 1'b0, 8'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0000);
    tbl[3]  = mk(1'b1, 16'h0044, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b1, 8'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tbl[4]  = mk(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tbl[5]  = mk(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tbl[6]  = mk(1'b1, 16'h00AA, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 1'b1, 8'd0, 16'h0011, 16'h0022, 16'h0033, 16'h0044);
    tbl[7]  = mk(1'b1, 16'h0055, 1'b1, 1'b0, 1'b1, 2'd1, 4'b0001, 1'b0, 8'd1, 16'h0055, 16'h0022, 16'h0033, 16'h0044);
    tbl[8]  = mk(1'b1, 16'h0066, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 1'b0, 8'd1, 16'h0055, 16'h0066, 16'h0033, 16'h0044);
    tbl[9]  = mk(1'b1, 16'h0077, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0100, 1'b0, 8'd1, 16'h0055, 16'h0066, 16'h0077, 16'h0044);
    tbl[10] = mk(1'b1, 16'h0088, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b1, 8'd1, 16'h0055, 16'h0066, 16'h0077, 16'h0088);
    tbl[11] = mk(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 8'd2, 16'h0055, 16'h0066, 16'h0077, 16'h0088);
    tbl[12] = mk(1'b1, 16'h1234, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0001, 1'b0, 8'd2, 16'h1234, 16'h0066, 16'h0077, 16'h0088);
    tbl[13] = mk(1'b1, 16'h5678, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 1'b0, 8'd2, 16'h1234, 16'h5678, 16'h0077, 16'h0088);
    tbl[14] = mk(1'b1, 16'h9999, 1'b0, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[15] = mk(1'b1, 16'h00A1, 1'b0, 1'b0, 1'b1, 2'd1, 4'b0001, 1'b0, 8'd2, 16'h00A1, 16'h0000, 16'h0000, 16'h0000);
    tbl[16] = mk(1'b1, 16'h00A2, 1'b0, 1'b0, 1'b1, 2'd2, 4'b0010, 1'b0, 8'd2, 16'h00A1, 16'h00A2, 16'h0000, 16'h0000);
    tbl[17] = mk(1'b1, 16'h00A3, 1'b0, 1'b0, 1'b1, 2'd3, 4'b0100, 1'b0, 8'd2, 16'h00A1, 16'h00A2, 16'h00A3, 16'h0000);
    tbl[18] = mk(1'b1, 16'h00A4, 1'b0, 1'b0, 1'b1, 2'd0, 4'b1000, 1'b1, 8'd2, 16'h00A1, 16'h00A2, 16'h00A3, 16'h00A4);
    tbl[19] = mk(1'b1, 16'hBBBB, 1'b1, 1'b1, 1'b0, 2'd0, 4'b0000, 1'b0, 8'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    tbl[20] = mk(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 2'd0, 4'b0000, 1'b0, 8'd2, 16'h0000, 16'h0000, 16'h0000, 16'h0000);

    rst_n = 1'b0; flush = 1'b0; in_data = 16'h0000; in_valid = 1'b0; vec_ready = 1'b0;
    #22;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("reset", 2'd0, 4'b0000, 1'b0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    chk("reset.in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 21; i++) begin
      step(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      chk($sformatf("row%0d.in_ready", i), {31'd0, ir_pre}, {31'd0, tbl[i].ir});
      chk_all($sformatf("row%0d", i), tbl[i].sel, tbl[i].we, tbl[i].vv, tbl[i].cnt,
              tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].l3);
    end

    // Continuous stream: 16 words with in_valid and vec_ready tied high.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] w;
      logic [7:0]  ec;
      logic [3:0]  ewe;
      logic [1:0]  esel;
      logic [15:0] lane_act;
      w    = 16'h0100 + 16'(i);
      ec   = 8'd2 + 8'(i / 4);
      ewe  = 4'b0001 << (i % 4);
      esel = 2'((i + 1) % 4);
      step(1'b1, w, 1'b1, 1'b0);
      chk($sformatf("stream%0d.in_ready", i), {31'd0, ir_pre}, 32'd1);
      chk($sformatf("stream%0d.lane_we", i), {28'd0, lane_we}, {28'd0, ewe});
      chk($sformatf("stream%0d.sel", i), {30'd0, sel}, {30'd0, esel});
      chk($sformatf("stream%0d.vec_valid", i), {31'd0, vec_valid}, {31'd0, (i % 4) == 3});
      chk($sformatf("stream%0d.vec_cnt", i), {24'd0, vec_cnt}, {24'd0, ec});
      chk($sformatf("stream%0d.vec_cnt2", i), {30'd0, vec_cnt2}, {30'd0, ec[1:0]});
      case (i % 4)
        0:       lane_act = lane_0;
        1:       lane_act = lane_1;
        2:       lane_act = lane_2;
        default: lane_act = lane_3;
      endcase
      chk($sformatf("stream%0d.lane", i), {16'd0, lane_act}, {16'd0, w});
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    chk("stream_end.vec_cnt", {24'd0, vec_cnt}, 32'd6);
    chk("stream_end.vec_cnt2", {30'd0, vec_cnt2}, 32'd2);
    chk("stream_end.vec_valid", {31'd0, vec_valid}, 32'd0);
    chk("stream_end.lane_we", {28'd0, lane_we}, 32'd0);

    // Asynchronous reset after three words, checked before the next edge.
    step(1'b1, 16'h0C01, 1'b0, 1'b0);
    step(1'b1, 16'h0C02, 1'b0, 1'b0);
    step(1'b1, 16'h0C03, 1'b0, 1'b0);
    chk("pre_rst.sel", {30'd0, sel}, 32'd3);
    chk("pre_rst.lane_we", {28'd0, lane_we}, 32'd4);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 2'd0, 4'b0000, 1'b0, 8'd0, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h0D01, 1'b0, 1'b0);
    chk_all("post_rst", 2'd1, 4'b0001, 1'b0, 8'd0, 16'h0D01, 16'h0000, 16'h0000, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1);
  end

endmodule

// File: doc/demux_fill_ctrl.md
Name: demux_fill_ctrl

Overview:
- Sequencer for the 1-to-4 16-bit demultiplexer feeding the autoencoder neuron-input registers.
- Accepts a serial valid/ready word stream, drives the demux select round-robin (lane 0..3) and captures each word into its lane register.
- Presents the completed 4-word vector to the downstream neuron layer with a valid/ready handshake and counts delivered vectors.

Parameters:
- DATA_W, 16, width of each data word and lane register.
- CNT_W, 8, width of the delivered-vector counter.

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous abort; discards a partially filled vector.
- in_data  input  DATA_W  serial input word.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  controller accepts in_data this cycle.
- sel  output  2  demux select: lane index the next accepted word is written to.
- lane_we  output  4  one-hot write strobe, registered, pulses the cycle after a word is accepted.
- lane_0 .. lane_3  output  DATA_W each  captured lane registers.
- vec_valid  output  1  all four lanes hold a complete vector.
- vec_ready  input  1  downstream consumes the vector.
- vec_cnt  output  CNT_W  number of vectors delivered since reset.

Behaviour:
- Reset (rst_n low, asynchronous): state FILL, sel = 0, lane_we = 0, lane_0..3 = 0, vec_valid = 0, vec_cnt = 0.
- Word handshake: accept = in_valid & in_ready.
- Vector handshake: take = vec_valid & vec_ready.
- States:
  - FILL: vec_valid = 0, in_ready = 1. On accept, lane[sel] <= in_data and lane_we <= (1 << sel).
    - If sel < 3: sel increments.
    - If sel == 3: sel <= 0 and the next state is FULL.
  - FULL: vec_valid = 1 and in_ready = vec_ready (combinational pass-through). Lanes are held stable.
    - On take without accept: vec_cnt increments and the next state is FILL.
    - On take with accept in the same cycle: vec_cnt increments, lane_0 <= in_data, lane_we = 0001, sel <= 1, next state FILL. This sustains one word per cycle with no bubble.
    - in_valid without vec_ready: the word is not accepted and the lanes are unchanged.
- Latency: the 4th accepted word raises vec_valid on the next rising edge. A lane register is updated on the edge after its word is accepted.
- lane_we is a 1-cycle pulse, exactly one bit per accepted word. It is 0 in every other cycle.
- sel only ever takes values 0..3. It wraps 3 -> 0 and never holds an out-of-range value.
- vec_cnt wraps at 2^CNT_W-1 -> 0 with no saturation.
- flush (synchronous, highest priority over accept and take):
  - next state FILL, sel <= 0, vec_valid <= 0, lane_we <= 0, lanes cleared to 0.
  - vec_cnt is not incremented, even if take occurs in the same cycle.
  - in_ready is forced to 0 while flush is high, so no word is lost silently.
- Asynchronous reset in the middle of a fill discards all state immediately; no partial vector survives reset.
- No combinational path from in_valid to in_ready.
- Combinational paths from vec_ready to in_ready exist in state FULL only.

Test Plan:
- Reset, then stream 0x0011, 0x0022, 0x0033, 0x0044 on consecutive cycles with vec_ready = 0.
  -> sel steps 0,1,2,3,0; lane_we steps 0001,0010,0100,1000.
  -> lane_0..3 = 0x0011/0x0022/0x0033/0x0044; vec_valid = 1 one cycle after the 4th word; in_ready = 0 while held.
- From FULL, hold in_valid = 1 with data 0x00AA for 3 cycles, then raise vec_ready for 1 cycle with in_valid = 1, data 0x0055.
  -> lanes unchanged during the hold; then vec_cnt = 1, lane_0 = 0x0055, sel = 1, vec_valid = 0.
- Continuous stream of 16 words with in_valid and vec_ready both tied to 1.
  -> 4 vectors delivered; vec_cnt = 4; in_ready never drops; no cycle lacks an accepted word.
- Load 2 words (0x1234, 0x5678), then assert flush for 1 cycle.
  -> sel = 0, lanes = 0, vec_valid = 0, vec_cnt unchanged.
  -> Next 4 words form a fresh vector starting at lane_0.
- Assert rst_n low asynchronously mid-cycle after 3 words.
  -> all outputs return to reset values before the next clock edge.
- Set CNT_W = 2 and deliver 5 vectors.
  -> vec_cnt sequence is 1,2,3,0,1.
